// File: rtl/alu_share_sequencer.sv
// Shares one ALU between two requesters (port 0 address update, port 1 execute).
// Multi-bit shifts are issued to the ALU as one-bit passes, one per clock.
module alu_share_sequencer #(
  parameter int WIDTH = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [WIDTH-1:0] req0_in2,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [WIDTH-1:0] req1_in2,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  localparam logic [2:0] OP_SHIFT = 3'b010;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [3:0]       remaining;
  logic             pass_mode;
  logic             orig_zero;

  logic [1:0]       grant;
  logic             sel;
  logic [WIDTH-1:0] sel_in1;
  logic [WIDTH-1:0] sel_in2;
  logic [2:0]       sel_op;
  logic [3:0]       sel_count;
  logic [3:0]       sel_shop;
  logic             sel_pass;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_EN && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Gated by rst_n so nothing is offered while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;

  assign sel       = grant[1];
  assign sel_in1   = sel ? req1_in1 : req0_in1;
  assign sel_in2   = sel ? req1_in2 : req0_in2;
  assign sel_op    = sel ? req1_op  : req0_op;
  assign sel_count = sel_in2[7:4];
  assign sel_shop  = sel_in2[3:0];
  assign sel_pass  = (sel_op == OP_SHIFT) && (sel_count != 4'd0) &&
                     (sel_shop >= 4'd1) && (sel_shop <= 4'd3);

  // alu_in1 doubles as the shift accumulator: each pass feeds alu_out back in.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      remaining  <= 4'd0;
      pass_mode  <= 1'b0;
      orig_zero  <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= 3'b000;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner     <= sel;
            alu_in1   <= sel_in1;
            alu_op    <= sel_op;
            alu_in2   <= sel_pass ? {{(WIDTH-8){1'b0}}, 4'h1, sel_shop} : sel_in2;
            pass_mode <= sel_pass;
            orig_zero <= (sel_in1 == sel_in2);
            remaining <= sel_count - 4'd1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_err  <= 1'b0;
          // During a shift pass the ALU sees the one-bit control word, not in2.
          rsp_zero <= pass_mode ? orig_zero : alu_zero;
          if (alu_op inside {3'b101, 3'b110, 3'b111}) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            state      <= RESP;
          end else if (pass_mode) begin
            alu_in1 <= alu_out;
            if (remaining == 4'd0) begin
              rsp_result <= alu_out;
              rsp_valid  <= owner ? 2'b10 : 2'b01;
              state      <= RESP;
            end else begin
              state <= SHIFT;
            end
          end else if (alu_op == OP_SHIFT) begin
            rsp_result <= alu_in1;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            state      <= RESP;
          end else begin
            rsp_result <= alu_out;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            state      <= RESP;
          end
        end
        SHIFT: begin
          alu_in1   <= alu_out;
          remaining <= remaining - 4'd1;
          if (remaining == 4'd1) begin
            rsp_result <= alu_out;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            state      <= RESP;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Bench for alu_share_sequencer: behavioural ALU, a vector table, scoreboard
// queues for expected/observed responses, and reset/abort/arbitration sequences.
module tb_alu_share_sequencer;

  typedef struct {
    int          port;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  op;
    logic [15:0] result;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    int          port;
    logic [15:0] result;
    logic        zero;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] result;
    logic        zero;
    logic        err;
    int          cyc;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]  req0_op, req1_op;

  logic [1:0]  a_req_ready, a_rsp_valid;
  logic [15:0] a_alu_in1, a_alu_in2, a_alu_out, a_rsp_result;
  logic [2:0]  a_alu_op;
  logic        a_alu_zero, a_rsp_zero, a_rsp_err;

  logic [1:0]  b_req_ready, b_rsp_valid;
  logic [15:0] b_alu_in1, b_alu_in2, b_alu_out, b_rsp_result;
  logic [2:0]  b_alu_op;
  logic        b_alu_zero, b_rsp_zero, b_rsp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];

  // Shift count comes from in2[7:4], shift kind from in2[3:0]; 16'hDEAD stands
  // in for the high-Z output of the reserved opcodes.
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    logic [3:0] cnt;
    cnt = b[7:4];
    case (op)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b011: return a & b;
      3'b100: return a | b;
      3'b010: begin
        case (b[3:0])
          4'd1:    return a << cnt;
          4'd2:    return a >> cnt;
          4'd3:    return 16'($signed(a) >>> cnt);
          default: return a;
        endcase
      end
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic vec_t model(input int p, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op);
    vec_t v;
    v.port   = p;
    v.in1    = a;
    v.in2    = b;
    v.op     = op;
    v.zero   = (a == b);
    v.err    = (op >= 3'b101);
    v.result = v.err ? 16'h0000 : alu_fn(a, b, op);
    v.lat    = (op == 3'b010 && b[7:4] != 4'd0 && b[3:0] >= 4'd1 && b[3:0] <= 4'd3)
               ? 1 + int'(b[7:4]) : 2;
    return v;
  endfunction

  assign a_alu_out  = alu_fn(a_alu_in1, a_alu_in2, a_alu_op);
  assign a_alu_zero = (a_alu_in1 == a_alu_in2);
  assign b_alu_out  = alu_fn(b_alu_in1, b_alu_in2, b_alu_op);
  assign b_alu_zero = (b_alu_in1 == b_alu_in2);

  alu_share_sequencer #(.WIDTH(16), .RR_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(a_alu_in1), .alu_in2(a_alu_in2), .alu_op(a_alu_op),
    .alu_out(a_alu_out), .alu_zero(a_alu_zero),
    .rsp_valid(a_rsp_valid), .rsp_result(a_rsp_result),
    .rsp_zero(a_rsp_zero), .rsp_err(a_rsp_err)
  );

  alu_share_sequencer #(.WIDTH(16), .RR_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_op(b_alu_op),
    .alu_out(b_alu_out), .alu_zero(b_alu_zero),
    .rsp_valid(b_rsp_valid), .rsp_result(b_rsp_result),
    .rsp_zero(b_rsp_zero), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && a_rsp_valid != 2'b00)
      obs_q.push_back('{a_rsp_valid, a_rsp_result, a_rsp_zero, a_rsp_err, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back('{v.port, v.result, v.zero, v.err, cyc + v.lat});
  endtask

  task automatic set_port(input vec_t v);
    if (v.port == 0) begin
      req0_in1 = v.in1; req0_in2 = v.in2; req0_op = v.op;
    end else begin
      req1_in1 = v.in1; req1_in2 = v.in2; req1_op = v.op;
    end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send(input vec_t v, input bit expect_rsp);
    bit done;
    done = 1'b0;
    set_port(v);
    req_valid[v.port] = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (a_req_ready[v.port]) begin
        done = 1'b1;
        if (expect_rsp) push_exp(v);
      end
      @(posedge clk); #1;
    end
    req_valid[v.port] = 1'b0;
    check("handshake", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int   n;
    exp_t e;
    obs_t o;
    while (exp_q.size() != 0) begin
      n = 0;
      while (obs_q.size() == 0 && n < 40) begin
        @(negedge clk); #1;
        n++;
      end
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check("rsp_timeout", 32'd0, 32'd1);
      end else begin
        o = obs_q.pop_front();
        check("rsp_port",   32'(o.valid),  (e.port == 1) ? 32'd2 : 32'd1);
        check("rsp_result", 32'(o.result), 32'(e.result));
        check("rsp_zero",   32'(o.zero),   32'(e.zero));
        check("rsp_err",    32'(o.err),    32'(e.err));
        check("rsp_cycle",  32'(o.cyc),    32'(e.cyc));
      end
    end
    repeat (3) @(negedge clk);
    #1;
    check("extra_rsp", 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t       vecs[16];
    vec_t       v0, v1;
    logic [1:0] ga[4];
    logic [1:0] gb[4];
    int         na, nb;

    vecs[0]  = '{1, 16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1'b0, 2};
    vecs[1]  = '{0, 16'h8001, 16'h0053, 3'b010, 16'hFC00, 1'b0, 1'b0, 6};
    vecs[2]  = '{0, 16'h1234, 16'h1234, 3'b110, 16'h0000, 1'b1, 1'b1, 2};
    vecs[3]  = '{1, 16'h0005, 16'h0007, 3'b001, 16'hFFFE, 1'b0, 1'b0, 2};
    vecs[4]  = '{0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[5]  = '{1, 16'hF0F0, 16'hFF00, 3'b011, 16'hF000, 1'b0, 1'b0, 2};
    vecs[6]  = '{1, 16'hF0F0, 16'h0F0F, 3'b100, 16'hFFFF, 1'b0, 1'b0, 2};
    vecs[7]  = '{0, 16'h0001, 16'h00F1, 3'b010, 16'h8000, 1'b0, 1'b0, 16};
    vecs[8]  = '{1, 16'h8000, 16'h0032, 3'b010, 16'h1000, 1'b0, 1'b0, 4};
    vecs[9]  = '{0, 16'hABCD, 16'h0003, 3'b010, 16'hABCD, 1'b0, 1'b0, 2};
    vecs[10] = '{1, 16'hABCD, 16'h0034, 3'b010, 16'hABCD, 1'b0, 1'b0, 2};
    vecs[11] = '{0, 16'h4000, 16'h0013, 3'b010, 16'h2000, 1'b0, 1'b0, 2};
    vecs[12] = '{1, 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b0, 1'b0, 2};
    vecs[13] = '{0, 16'h0000, 16'h0000, 3'b111, 16'h0000, 1'b1, 1'b1, 2};
    vecs[14] = '{0, 16'h0022, 16'h0022, 3'b010, 16'h0008, 1'b1, 1'b0, 3};
    vecs[15] = '{1, 16'h8000, 16'h00F3, 3'b010, 16'hFFFF, 1'b0, 1'b0, 16};

    // Reset held with both ports requesting.
    rst_n = 1'b0;
    v0 = model(0, 16'h0003, 16'h0004, 3'b000);
    v1 = model(1, 16'h0010, 16'h0001, 3'b001);
    set_port(v0);
    set_port(v1);
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_a",  32'(a_req_ready),  32'd0);
    check("rst_ready_b",  32'(b_req_ready),  32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_result",   32'(a_rsp_result), 32'd0);
    check("rst_zero_err", 32'({a_rsp_zero, a_rsp_err}), 32'd0);
    check("rst_alu_in",   32'({a_alu_in1, a_alu_in2}), 32'd0);
    check("rst_alu_op",   32'(a_alu_op),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both ports held valid: dut_a alternates, dut_b keeps granting port 0.
    na = 0;
    nb = 0;
    for (int n = 0; n < 30 && (na < 4 || nb < 4); n++) begin
      @(negedge clk);
      if (a_req_ready != 2'b00 && na < 4) begin
        ga[na] = a_req_ready;
        na++;
        push_exp(a_req_ready[1] ? v1 : v0);
      end
      if (b_req_ready != 2'b00 && nb < 4) begin
        gb[nb] = b_req_ready;
        nb++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("rr_count_a", 32'(na), 32'd4);
    check("rr_count_b", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < na) check("rr_grant_a", 32'(ga[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i < nb) check("fixed_grant_b", 32'(gb[i]), 32'd1);
    end
    drain();

    for (int i = 0; i < 16; i++) begin
      send(vecs[i], 1'b1);
      drain();
    end

    // Port 1 raises valid while busy, then withdraws without a handshake.
    send(model(0, 16'h00F0, 16'h0031, 3'b010), 1'b1);
    req1_in1 = 16'h5555;
    req1_in2 = 16'h1111;
    req1_op  = 3'b000;
    req_valid[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("busy_ready", 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    drain();

    // Reset in the middle of a 15-pass shift drops it silently.
    send(model(0, 16'h8001, 16'h00F1, 3'b010), 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("abort_alu_in1",   32'(a_alu_in1),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    send(model(1, 16'h1111, 16'h2222, 3'b000), 1'b1);
    drain();
    send(model(0, 16'h8001, 16'h0053, 3'b010), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
